fiber_pack_addr_gen: RTL and testbench

Parametrised successor to the fiber-side packer and address generator. Packs NCH complex (I/Q) channels into NWORD RAM words per sample and generates a per-PRI write address sequence for the dual-port frame RAM. Frame length is loaded through a shadow register and committed on each PRI edge. After each completed frame it drives fibertx_en for a programmable window. Sits between the beamformer/DDC outputs and the fiber TX RAM.

---
 rtl/fiber_pack_addr_gen_if.sv | 36 +++
 rtl/fiber_pack_addr_gen.sv | 186 ++++++++++++++++++
 tb/tb_fiber_pack_addr_gen.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fiber_pack_addr_gen_if.sv
// Sample/config inputs and RAM-write outputs of the fiber packer; master is the source side, slave is the packer.
// One interface instance per packer; widths follow the packer parameters.
interface fiber_pack_addr_gen_if #(
    parameter int NCH    = 14,
    parameter int SW     = 16,
    parameter int WORD_W = 128,
    parameter int ADDR_W = 14
);
    localparam int NWORD = (2*NCH*SW + WORD_W - 1) / WORD_W;

    logic                    pri;
    logic [31:0]             pri_cnt;
    logic [NCH*SW-1:0]       din_i;
    logic [NCH*SW-1:0]       din_q;
    logic                    data_valid;
    logic [2:0]              test_mode;
    logic [15:0]             nr_cfg;
    logic                    nr_cfg_wr;
    logic [NWORD*WORD_W-1:0] ram_din;
    logic                    ram_we;
    logic [ADDR_W-1:0]       ram_addr;
    logic                    frame_done;
    logic [15:0]             frame_cnt;
    logic                    frame_short;
    logic                    fibertx_en;

    modport master (
        output pri, pri_cnt, din_i, din_q, data_valid, test_mode, nr_cfg, nr_cfg_wr,
        input  ram_din, ram_we, ram_addr, frame_done, frame_cnt, frame_short, fibertx_en
    );

    modport slave (
        input  pri, pri_cnt, din_i, din_q, data_valid, test_mode, nr_cfg, nr_cfg_wr,
        output ram_din, ram_we, ram_addr, frame_done, frame_cnt, frame_short, fibertx_en
    );
endinterface

// File: rtl/fiber_pack_addr_gen.sv
// Packs NCH I/Q channels into NWORD RAM words and writes one frame per PRI; ram_* registered 1 cycle after data_valid.
// No backpressure: the RAM accepts every write. Macro FIBER_HDR_EN adds a header word at address 0 per frame.
module fiber_pack_addr_gen #(
    parameter int NCH        = 14,
    parameter int SW         = 16,
    parameter int WORD_W     = 128,
    parameter int ADDR_W     = 14,
    parameter int NR_DEFAULT = 11100,
    parameter int TX_EN_CYC  = 240
) (
    input  logic                 clk_120m,
    input  logic                 FPGA_RESET,
    fiber_pack_addr_gen_if.slave bus
);
    localparam int NWORD = (2*NCH*SW + WORD_W - 1) / WORD_W;
    localparam int DW    = NWORD * WORD_W;
    localparam int SPW   = WORD_W / SW;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TXW   = $clog2(TX_EN_CYC + 1);
`ifdef FIBER_HDR_EN
    localparam bit HDR_EN = 1'b1;
    localparam int NR_MAX = DEPTH - 1;
`else
    localparam bit HDR_EN = 1'b0;
    localparam int NR_MAX = DEPTH;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_t;

    state_t            state, state_nxt;
    logic              p1, p2, pri_rise;
    logic [15:0]       nr_pending, nr_active, nr_src, nr_commit;
    logic [15:0]       n, n_nxt, n_addr;
    logic              hdr_pend, hdr_nxt;
    logic              skid_vld, skid_ld;
    logic [DW-1:0]     skid_dat;
    logic [SW-1:0]     tcnt;
    logic [SW-1:0]     slot;
    logic [DW-1:0]     pack, hdr_word;
    logic              start, accept, wr_hdr, wr_smp, wr_from_skid;
    logic [DW-1:0]     ram_din_r;
    logic              ram_we_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [15:0]       frame_cnt_r;
    logic              frame_short_r;
    logic [TXW-1:0]    tx_cnt;

    assign pri_rise  = p1 & ~p2;
    // A config write in the same cycle as the PRI edge is the value that gets committed.
    assign nr_src    = bus.nr_cfg_wr ? bus.nr_cfg : nr_pending;
    assign nr_commit = (32'(nr_src) > NR_MAX) ? 16'(NR_MAX) : nr_src;
    assign n_addr    = HDR_EN ? n + 16'd1 : n;

    always_comb begin
        pack = '0;
        slot = '0;
        for (int j = 0; j < 2*NCH; j++) begin
            case (bus.test_mode)
                3'd0:    slot = (j % 2 == 1) ? bus.din_q[(j/2)*SW +: SW] : bus.din_i[(j/2)*SW +: SW];
                3'd1:    slot = tcnt;
                3'd2:    slot = bus.pri_cnt[SW-1:0];
                3'd3:    slot = SW'(j/2 + 1) | ((j % 2 == 1) ? {1'b1, {(SW-1){1'b0}}} : '0);
                default: slot = '0;
            endcase
            // Slot 0 sits at the MSB of word 0; word w occupies [w*WORD_W +: WORD_W].
            pack[(j/SPW)*WORD_W + (SPW-1-(j%SPW))*SW +: SW] = slot;
        end
    end

    // Header fields fill the top 112 bits of word 0; the remaining bits are zero.
    always_comb begin
        hdr_word = '0;
        hdr_word[WORD_W-1 -: 112] = {16'hA55A, frame_cnt_r, nr_active, bus.pri_cnt, 32'h0};
    end

    always_comb begin
        state_nxt    = state;
        n_nxt        = n;
        hdr_nxt      = hdr_pend;
        start        = 1'b0;
        accept       = 1'b0;
        skid_ld      = 1'b0;
        wr_hdr       = 1'b0;
        wr_smp       = 1'b0;
        wr_from_skid = 1'b0;
        case (state)
            ST_IDLE: start = pri_rise;
            ST_WRITE: begin
                if (pri_rise) begin
                    start = 1'b1;
                end else if (hdr_pend) begin
                    // A sample arriving with the header is parked for one cycle.
                    wr_hdr  = 1'b1;
                    hdr_nxt = 1'b0;
                    accept  = bus.data_valid;
                    skid_ld = bus.data_valid;
                end else if (skid_vld) begin
                    wr_smp       = 1'b1;
                    wr_from_skid = 1'b1;
                    accept       = bus.data_valid;
                    skid_ld      = bus.data_valid;
                end else if (bus.data_valid) begin
                    wr_smp = 1'b1;
                    accept = 1'b1;
                end
            end
            ST_DONE: begin
                start     = pri_rise;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (wr_smp) begin
            n_nxt = n + 16'd1;
            if (n == nr_active - 16'd1)
                state_nxt = ST_DONE;
        end
        if (start) begin
            n_nxt     = '0;
            hdr_nxt   = HDR_EN;
            state_nxt = (nr_commit == 16'd0) ? ST_DONE : ST_WRITE;
        end
    end

    always_ff @(posedge clk_120m) begin
        if (FPGA_RESET) begin
            state         <= ST_IDLE;
            p1            <= 1'b0;
            p2            <= 1'b0;
            nr_pending    <= 16'(NR_DEFAULT);
            nr_active     <= 16'(NR_DEFAULT);
            n             <= '0;
            hdr_pend      <= 1'b0;
            skid_vld      <= 1'b0;
            skid_dat      <= '0;
            tcnt          <= '0;
            ram_din_r     <= '0;
            ram_we_r      <= 1'b0;
            ram_addr_r    <= '0;
            frame_cnt_r   <= '0;
            frame_short_r <= 1'b0;
            tx_cnt        <= '0;
        end else begin
            p1       <= bus.pri;
            p2       <= p1;
            state    <= state_nxt;
            n        <= n_nxt;
            hdr_pend <= hdr_nxt;
            skid_vld <= skid_ld && (state_nxt == ST_WRITE);
            if (skid_ld)
                skid_dat <= pack;
            if (bus.nr_cfg_wr)
                nr_pending <= bus.nr_cfg;
            if (pri_rise)
                nr_active <= nr_commit;
            if (pri_rise)
                tcnt <= '0;
            else if (accept)
                tcnt <= tcnt + 1'b1;
            ram_we_r <= wr_hdr | wr_smp;
            if (wr_hdr) begin
                ram_din_r  <= hdr_word;
                ram_addr_r <= '0;
            end else if (wr_smp) begin
                ram_din_r  <= wr_from_skid ? skid_dat : pack;
                ram_addr_r <= ADDR_W'(n_addr);
            end
            if (state == ST_DONE)
                frame_cnt_r <= frame_cnt_r + 16'd1;
            if (state == ST_WRITE && pri_rise)
                frame_short_r <= 1'b1;
            if (state == ST_DONE)
                tx_cnt <= TXW'(TX_EN_CYC);
            else if (tx_cnt != '0)
                tx_cnt <= tx_cnt - 1'b1;
        end
    end

    assign bus.ram_din     = ram_din_r;
    assign bus.ram_we      = ram_we_r;
    assign bus.ram_addr    = ram_addr_r;
    assign bus.frame_done  = (state == ST_DONE);
    assign bus.frame_cnt   = frame_cnt_r;
    assign bus.frame_short = frame_short_r;
    assign bus.fibertx_en  = (tx_cnt != '0);
endmodule

// File: tb/tb_fiber_pack_addr_gen.sv
// Directed bench for fiber_pack_addr_gen at default parameters; a negedge monitor logs RAM writes and pulses.
`timescale 1ns/1ps
module tb_fiber_pack_addr_gen;
    localparam int DW = 512;

    logic clk_120m = 1'b0;
    logic FPGA_RESET = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    fiber_pack_addr_gen_if bus ();
    fiber_pack_addr_gen dut (.clk_120m(clk_120m), .FPGA_RESET(FPGA_RESET), .bus(bus));

    always #4 clk_120m = ~clk_120m;
    always @(posedge clk_120m) cyc <= cyc + 1;

    logic [13:0]   wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            wc_q[$];
    int            drv_q[$];
    int            fd_cnt = 0;
    int            tx_hi = 0;

    always @(negedge clk_120m) begin
        if (bus.ram_we) begin
            wa_q.push_back(bus.ram_addr);
            wd_q.push_back(bus.ram_din);
            wc_q.push_back(cyc);
        end
        if (bus.frame_done) fd_cnt++;
        if (bus.fibertx_en) tx_hi++;
    end

    task automatic tick();
        @(posedge clk_120m);
        #1;
    endtask

    task automatic set_din(input logic [7:0] s);
        for (int k = 0; k < 14; k++) begin
            bus.din_i[k*16 +: 16] = {4'hA, 4'(k), s};
            bus.din_q[k*16 +: 16] = {4'hB, 4'(k), s};
        end
    endtask

    task automatic send(input int cnt, input logic [7:0] base);
        for (int i = 0; i < cnt; i++) begin
            set_din(base + 8'(i));
            bus.data_valid = 1'b1;
            drv_q.push_back(cyc);
            tick();
        end
        bus.data_valid = 1'b0;
    endtask

    task automatic load_nr(input logic [15:0] v);
        bus.nr_cfg    = v;
        bus.nr_cfg_wr = 1'b1;
        tick();
        bus.nr_cfg_wr = 1'b0;
    endtask

    // pri_rise is seen in the cycle after the first tick; an optional config write lands on it.
    task automatic pulse_pri(input bit wr, input logic [15:0] v);
        bus.pri = 1'b1;
        tick();
        if (wr) begin
            bus.nr_cfg    = v;
            bus.nr_cfg_wr = 1'b1;
        end
        tick();
        bus.nr_cfg_wr = 1'b0;
        tick();
        bus.pri = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.pri = 0; bus.pri_cnt = 0; bus.din_i = '0; bus.din_q = '0; bus.data_valid = 0;
        bus.test_mode = 0; bus.nr_cfg = 0; bus.nr_cfg_wr = 0;
        FPGA_RESET = 1'b1;
        repeat (3) tick();
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", bus.ram_we); end
        checks++; if (bus.ram_addr !== 14'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", bus.ram_addr); end
        checks++; if (bus.ram_din !== {DW{1'b0}}) begin errors++; $display("FAIL reset_din: nonzero"); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", bus.frame_done); end
        checks++; if (bus.frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_fcnt: got %0d want 0", bus.frame_cnt); end
        checks++; if (bus.frame_short !== 1'b0) begin errors++; $display("FAIL reset_short: got %0b want 0", bus.frame_short); end
        checks++; if (bus.fibertx_en !== 1'b0) begin errors++; $display("FAIL reset_txen: got %0b want 0", bus.fibertx_en); end
        FPGA_RESET = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int b, d, f, t;
        logic [DW-1:0] w;
        b = wa_q.size(); d = drv_q.size(); f = fd_cnt; t = tx_hi;
        load_nr(16'd8);
        pulse_pri(1'b0, 16'd0);
        send(8, 8'd0);
        repeat (260) tick();
        checks++; if (wa_q.size() - b !== 8) begin errors++; $display("FAIL basic_nwr: got %0d want 8", wa_q.size() - b); end
        for (int i = 0; i < 8 && b + i < wa_q.size(); i++) begin
            checks++; if (wa_q[b+i] !== 14'(i)) begin errors++; $display("FAIL basic_addr[%0d]: got %0h want %0h", i, wa_q[b+i], i); end
            checks++; if (wc_q[b+i] !== drv_q[d+i] + 1) begin errors++; $display("FAIL basic_lat[%0d]: got cyc %0d want %0d", i, wc_q[b+i], drv_q[d+i] + 1); end
        end
        if (wd_q.size() >= b + 4) begin
            w = wd_q[b];
            checks++; if (w[127:0] !== 128'hA000_B000_A100_B100_A200_B200_A300_B300) begin errors++; $display("FAIL basic_w0: got %h", w[127:0]); end
            checks++; if (w[511:384] !== 128'hAC00_BC00_AD00_BD00_0000_0000_0000_0000) begin errors++; $display("FAIL basic_w3: got %h", w[511:384]); end
            w = wd_q[b+3];
            checks++; if (w[127:0] !== 128'hA003_B003_A103_B103_A203_B203_A303_B303) begin errors++; $display("FAIL basic_s3w0: got %h", w[127:0]); end
        end
        checks++; if (fd_cnt - f !== 1) begin errors++; $display("FAIL basic_done: got %0d want 1", fd_cnt - f); end
        checks++; if (bus.frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_fcnt: got %0d want 1", bus.frame_cnt); end
        checks++; if (tx_hi - t !== 240) begin errors++; $display("FAIL basic_txlen: got %0d want 240", tx_hi - t); end
        checks++; if (bus.fibertx_en !== 1'b0) begin errors++; $display("FAIL basic_txoff: got %0b want 0", bus.fibertx_en); end
        checks++; if (bus.frame_short !== 1'b0) begin errors++; $display("FAIL basic_short: got %0b want 0", bus.frame_short); end
    endtask

    task automatic test_pattern();
        int b;
        logic [2:0] modes [4] = '{3'd3, 3'd1, 3'd2, 3'd5};
        logic [DW-1:0] w;
        b = wa_q.size();
        bus.pri_cnt = 32'h1234_5678;
        load_nr(16'd4);
        pulse_pri(1'b0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            bus.test_mode  = modes[i];
            bus.data_valid = 1'b1;
            tick();
        end
        bus.data_valid = 1'b0;
        bus.test_mode  = 3'd0;
        repeat (5) tick();
        checks++; if (wa_q.size() - b !== 4) begin errors++; $display("FAIL pat_nwr: got %0d want 4", wa_q.size() - b); end
        if (wd_q.size() >= b + 4) begin
            w = wd_q[b];
            checks++; if (w[127:0] !== 128'h0001_8001_0002_8002_0003_8003_0004_8004) begin errors++; $display("FAIL pat_m3w0: got %h", w[127:0]); end
            checks++; if (w[511:384] !== 128'h000D_800D_000E_800E_0000_0000_0000_0000) begin errors++; $display("FAIL pat_m3w3: got %h", w[511:384]); end
            w = wd_q[b+1];
            checks++; if (w[127:0] !== 128'h0001_0001_0001_0001_0001_0001_0001_0001) begin errors++; $display("FAIL pat_m1w0: got %h", w[127:0]); end
            w = wd_q[b+2];
            checks++; if (w[127:0] !== 128'h5678_5678_5678_5678_5678_5678_5678_5678) begin errors++; $display("FAIL pat_m2w0: got %h", w[127:0]); end
            checks++; if (w[511:384] !== 128'h5678_5678_5678_5678_0000_0000_0000_0000) begin errors++; $display("FAIL pat_m2w3: got %h", w[511:384]); end
            w = wd_q[b+3];
            checks++; if (w !== {DW{1'b0}}) begin errors++; $display("FAIL pat_m5: got nonzero %h", w[127:0]); end
        end
        checks++; if (bus.frame_cnt !== 16'd2) begin errors++; $display("FAIL pat_fcnt: got %0d want 2", bus.frame_cnt); end
    endtask

    task automatic test_short();
        int b, f;
        b = wa_q.size(); f = fd_cnt;
        load_nr(16'd10);
        pulse_pri(1'b0, 16'd0);
        send(4, 8'd0);
        pulse_pri(1'b0, 16'd0);
        checks++; if (fd_cnt - f !== 0) begin errors++; $display("FAIL short_nodone: got %0d want 0", fd_cnt - f); end
        checks++; if (bus.frame_short !== 1'b1) begin errors++; $display("FAIL short_flag: got %0b want 1", bus.frame_short); end
        send(10, 8'd16);
        repeat (5) tick();
        checks++; if (wa_q.size() - b !== 14) begin errors++; $display("FAIL short_nwr: got %0d want 14", wa_q.size() - b); end
        if (wa_q.size() >= b + 14) begin
            checks++; if (wa_q[b+3] !== 14'd3) begin errors++; $display("FAIL short_a3: got %0h want 3", wa_q[b+3]); end
            checks++; if (wa_q[b+4] !== 14'd0) begin errors++; $display("FAIL short_restart: got %0h want 0", wa_q[b+4]); end
            checks++; if (wa_q[b+13] !== 14'd9) begin errors++; $display("FAIL short_last: got %0h want 9", wa_q[b+13]); end
        end
        checks++; if (fd_cnt - f !== 1) begin errors++; $display("FAIL short_done: got %0d want 1", fd_cnt - f); end
        checks++; if (bus.frame_cnt !== 16'd3) begin errors++; $display("FAIL short_fcnt: got %0d want 3", bus.frame_cnt); end
    endtask

    task automatic test_shadow();
        int b, f;
        b = wa_q.size(); f = fd_cnt;
        load_nr(16'd8);
        pulse_pri(1'b0, 16'd0);
        send(3, 8'd0);
        load_nr(16'd20);
        send(5, 8'd3);
        repeat (5) tick();
        checks++; if (wa_q.size() - b !== 8) begin errors++; $display("FAIL shadow_cur: got %0d want 8", wa_q.size() - b); end
        checks++; if (fd_cnt - f !== 1) begin errors++; $display("FAIL shadow_done: got %0d want 1", fd_cnt - f); end
        b = wa_q.size();
        pulse_pri(1'b0, 16'd0);
        send(22, 8'd0);
        repeat (5) tick();
        checks++; if (wa_q.size() - b !== 20) begin errors++; $display("FAIL shadow_next: got %0d want 20", wa_q.size() - b); end
        if (wa_q.size() >= b + 20) begin
            checks++; if (wa_q[b+19] !== 14'd19) begin errors++; $display("FAIL shadow_last: got %0h want 13", wa_q[b+19]); end
        end
        checks++; if (bus.frame_cnt !== 16'd5) begin errors++; $display("FAIL shadow_fcnt: got %0d want 5", bus.frame_cnt); end
        b = wa_q.size();
        pulse_pri(1'b1, 16'd5);
        send(5, 8'd0);
        repeat (238) tick();
        checks++; if (bus.fibertx_en !== 1'b1) begin errors++; $display("FAIL tx_restart: got %0b want 1", bus.fibertx_en); end
        repeat (3) tick();
        checks++; if (bus.fibertx_en !== 1'b0) begin errors++; $display("FAIL tx_end: got %0b want 0", bus.fibertx_en); end
        checks++; if (wa_q.size() - b !== 5) begin errors++; $display("FAIL shadow_same: got %0d want 5", wa_q.size() - b); end
        checks++; if (bus.frame_cnt !== 16'd6) begin errors++; $display("FAIL shadow_fcnt2: got %0d want 6", bus.frame_cnt); end
    endtask

    task automatic test_zero();
        int b, f;
        b = wa_q.size(); f = fd_cnt;
        load_nr(16'd0);
        pulse_pri(1'b0, 16'd0);
        send(2, 8'd0);
        repeat (3) tick();
        checks++; if (wa_q.size() - b !== 0) begin errors++; $display("FAIL zero_nwr: got %0d want 0", wa_q.size() - b); end
        checks++; if (fd_cnt - f !== 1) begin errors++; $display("FAIL zero_done: got %0d want 1", fd_cnt - f); end
        checks++; if (bus.frame_cnt !== 16'd7) begin errors++; $display("FAIL zero_fcnt: got %0d want 7", bus.frame_cnt); end
    endtask

    task automatic test_max();
        int b, f, bad;
        b = wa_q.size(); f = fd_cnt; bad = 0;
        load_nr(16'hFFFF);
        pulse_pri(1'b0, 16'd0);
        send(16389, 8'd0);
        repeat (5) tick();
        checks++; if (wa_q.size() - b !== 16384) begin errors++; $display("FAIL max_nwr: got %0d want 16384", wa_q.size() - b); end
        for (int i = 0; i < 16384 && b + i < wa_q.size(); i++)
            if (wa_q[b+i] !== 14'(i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL max_seq: got %0d bad addrs want 0", bad); end
        if (wa_q.size() >= b + 16384) begin
            checks++; if (wa_q[b+16383] !== 14'h3FFF) begin errors++; $display("FAIL max_last: got %0h want 3fff", wa_q[b+16383]); end
        end
        checks++; if (fd_cnt - f !== 1) begin errors++; $display("FAIL max_done: got %0d want 1", fd_cnt - f); end
        checks++; if (bus.frame_cnt !== 16'd8) begin errors++; $display("FAIL max_fcnt: got %0d want 8", bus.frame_cnt); end
        checks++; if (bus.frame_short !== 1'b1) begin errors++; $display("FAIL max_sticky: got %0b want 1", bus.frame_short); end
    endtask

    task automatic test_reset_mid();
        int b, f;
        load_nr(16'd8);
        pulse_pri(1'b0, 16'd0);
        send(3, 8'd0);
        bus.data_valid = 1'b1;
        FPGA_RESET     = 1'b1;
        tick();
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rmid_we: got %0b want 0", bus.ram_we); end
        checks++; if (bus.frame_cnt !== 16'd0) begin errors++; $display("FAIL rmid_fcnt: got %0d want 0", bus.frame_cnt); end
        checks++; if (bus.frame_short !== 1'b0) begin errors++; $display("FAIL rmid_short: got %0b want 0", bus.frame_short); end
        bus.data_valid = 1'b0;
        tick();
        FPGA_RESET = 1'b0;
        tick();
        b = wa_q.size(); f = fd_cnt;
        pulse_pri(1'b0, 16'd0);
        send(3, 8'd0);
        repeat (3) tick();
        checks++; if (wa_q.size() - b !== 3) begin errors++; $display("FAIL rmid_nwr: got %0d want 3", wa_q.size() - b); end
        if (wa_q.size() >= b + 1) begin
            checks++; if (wa_q[b] !== 14'd0) begin errors++; $display("FAIL rmid_a0: got %0h want 0", wa_q[b]); end
        end
        checks++; if (fd_cnt - f !== 0) begin errors++; $display("FAIL rmid_nodone: got %0d want 0", fd_cnt - f); end
    endtask

`ifdef FIBER_HDR_EN
    task automatic test_hdr();
        int b, f;
        logic [DW-1:0] w;
        b = wa_q.size(); f = fd_cnt;
        bus.pri_cnt   = 32'h1234_5678;
        bus.test_mode = 3'd0;
        load_nr(16'd4);
        bus.pri = 1'b1;
        tick();
        tick();
        send(4, 8'd0);
        bus.pri = 1'b0;
        repeat (5) tick();
        checks++; if (wa_q.size() - b !== 5) begin errors++; $display("FAIL hdr_nwr: got %0d want 5", wa_q.size() - b); end
        if (wa_q.size() >= b + 5) begin
            w = wd_q[b];
            checks++; if (wa_q[b] !== 14'd0) begin errors++; $display("FAIL hdr_addr: got %0h want 0", wa_q[b]); end
            checks++; if (w[127:0] !== 128'hA55A_0000_0004_1234_5678_0000_0000_0000) begin errors++; $display("FAIL hdr_word: got %h", w[127:0]); end
            checks++; if (w[511:128] !== 384'h0) begin errors++; $display("FAIL hdr_rest: nonzero"); end
            for (int i = 1; i < 5; i++) begin
                checks++; if (wa_q[b+i] !== 14'(i)) begin errors++; $display("FAIL hdr_a[%0d]: got %0h want %0h", i, wa_q[b+i], i); end
            end
            w = wd_q[b+1];
            checks++; if (w[127:0] !== 128'hA000_B000_A100_B100_A200_B200_A300_B300) begin errors++; $display("FAIL hdr_s0: got %h", w[127:0]); end
            w = wd_q[b+4];
            checks++; if (w[127:0] !== 128'hA003_B003_A103_B103_A203_B203_A303_B303) begin errors++; $display("FAIL hdr_s3: got %h", w[127:0]); end
        end
        checks++; if (fd_cnt - f !== 1) begin errors++; $display("FAIL hdr_done: got %0d want 1", fd_cnt - f); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef FIBER_HDR_EN
        test_hdr();
`else
        test_basic();
        test_pattern();
        test_short();
        test_shadow();
        test_zero();
        test_max();
        test_reset_mid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
